tdoa_uart_scheduler: RTL and testbench

//  Shares the single uart_tx serializer between the four trigger-capture channels.

---
 rtl/tdoa_uart_scheduler.sv | 164 ++++++++++++++++
 tb/tb_tdoa_uart_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdoa_uart_scheduler.sv
// tdoa_uart_scheduler
// Round-robin scheduler that shares one uart_tx serializer between N_CH
// timestamp-capture channels. The granted channel's timestamp is framed as
// HDR_BYTE, channel id, timestamp bytes MSB first, and each byte is handed to
// uart_tx through its DV/active/done handshake.
// Optional feature: define CHECKSUM_EN to append one trailing XOR checksum byte.
module tdoa_uart_scheduler #(
  parameter int         N_CH     = 4,
  parameter int         TS_W     = 32,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_CH-1:0]      req,
  input  logic [N_CH*TS_W-1:0] ts_flat,
  output logic [N_CH-1:0]      ack,
  output logic                 tx_dv,
  output logic [7:0]           tx_byte,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 busy
);

  localparam int TS_BYTES = TS_W / 8;
`ifdef CHECKSUM_EN
  localparam int PKT_LEN = 3 + TS_BYTES;
`else
  localparam int PKT_LEN = 2 + TS_BYTES;
`endif
  localparam int IDX_W = $clog2(3 + TS_BYTES);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, SEND, WAIT} state_t;
  state_t state_reg, state_next;

  logic [CH_W-1:0]  rr_ptr_reg;
  logic [CH_W-1:0]  ch_reg;
  logic [CH_W-1:0]  pick;
  logic [TS_W-1:0]  ts_reg;
  logic [IDX_W-1:0] byte_idx_reg;
  logic [N_CH-1:0]  ack_reg;
  logic [N_CH-1:0]  ack_d_reg;
  logic [N_CH-1:0]  eligible;
  logic [N_CH-1:0]  pick_onehot;
  logic             tx_dv_reg;
  logic             busy_reg;
  logic             found;
  logic [7:0]       tx_byte_reg;
  logic [7:0]       pkt_byte;
  logic [7:0]       pkt [PKT_LEN];
  int               cand;

  // A requester may still hold req during its ack cycle and the one after;
  // those channels are masked so the same capture is never granted twice.
  assign eligible = req & ~(ack_reg | ack_d_reg);

  // Round-robin search: first eligible channel at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int i = 0; i < N_CH; i++) begin
      cand = int'(rr_ptr_reg) + i;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!found && eligible[cand[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[CH_W-1:0];
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_onehot
    assign pick_onehot[gi] = (pick == CH_W'(gi));
  end

  // Packet image built from the latched channel and timestamp only.
  assign pkt[0] = HDR_BYTE;
  assign pkt[1] = 8'(ch_reg);
  for (genvar gi = 0; gi < TS_BYTES; gi++) begin : g_ts_bytes
    assign pkt[2+gi] = ts_reg[(TS_BYTES-1-gi)*8 +: 8];
  end

`ifdef CHECKSUM_EN
  logic [7:0] csum;

  // Checksum covers header, id and every timestamp byte.
  always_comb begin
    csum = pkt[0] ^ pkt[1];
    for (int i = 0; i < TS_BYTES; i++) begin
      csum = csum ^ pkt[2+i];
    end
  end

  assign pkt[PKT_LEN-1] = csum;
`endif

  // Select the byte currently being offered to uart_tx.
  always_comb begin
    pkt_byte = 8'h00;
    if (byte_idx_reg <= LAST_IDX) pkt_byte = pkt[byte_idx_reg];
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic; SEND falls back to LOAD if the serializer became busy.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|eligible) state_next = GRANT;
      GRANT:   state_next = found ? LOAD : IDLE;
      LOAD:    if (!tx_active) state_next = SEND;
      SEND:    state_next = tx_active ? LOAD : WAIT;
      WAIT:    if (tx_done) state_next = (byte_idx_reg == LAST_IDX) ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: grant latch, byte staging, DV strobe and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg   <= '0;
      ch_reg       <= '0;
      ts_reg       <= '0;
      byte_idx_reg <= '0;
      ack_reg      <= '0;
      ack_d_reg    <= '0;
      tx_dv_reg    <= 1'b0;
      tx_byte_reg  <= 8'h00;
      busy_reg     <= 1'b0;
    end else begin
      ack_reg   <= '0;
      ack_d_reg <= ack_reg;
      tx_dv_reg <= 1'b0;
      case (state_reg)
        GRANT: if (found) begin
          ack_reg      <= pick_onehot;
          ch_reg       <= pick;
          ts_reg       <= ts_flat[pick*TS_W +: TS_W];
          busy_reg     <= 1'b1;
          rr_ptr_reg   <= (pick == CH_W'(N_CH - 1)) ? '0 : pick + 1'b1;
          byte_idx_reg <= '0;
        end
        LOAD:  tx_byte_reg <= pkt_byte;
        SEND:  if (!tx_active) tx_dv_reg <= 1'b1;
        WAIT:  if (tx_done) begin
          if (byte_idx_reg == LAST_IDX) busy_reg <= 1'b0;
          else                          byte_idx_reg <= byte_idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ack     = ack_reg;
  assign tx_dv   = tx_dv_reg;
  assign tx_byte = tx_byte_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_tdoa_uart_scheduler.sv
// Directed testbench for tdoa_uart_scheduler with a simple uart_tx stand-in.
// Build with +define+CHECKSUM_EN to check the checksum variant.
`timescale 1ns/1ps
module tb_tdoa_uart_scheduler;

  localparam int N_CH = 4;
  localparam int TS_W = 32;
`ifdef CHECKSUM_EN
  localparam int PKT_LEN = 7;
`else
  localparam int PKT_LEN = 6;
`endif
  localparam int BYTE_CYC = 10;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [N_CH-1:0]      req = '0;
  logic [N_CH*TS_W-1:0] ts_flat = '0;
  logic [N_CH-1:0]      ack;
  logic                 tx_dv;
  logic [7:0]           tx_byte;
  logic                 tx_active;
  logic                 tx_done;
  logic                 busy;

  logic model_active = 1'b0;
  logic model_done   = 1'b0;
  logic force_active = 1'b0;
  logic inj_done     = 1'b0;
  int   model_cnt    = 0;
  int   cyc          = 0;
  int   dv_viol      = 0;
  int   n_cmp        = 0;
  int   n_mis        = 0;

  logic [7:0]      rx_q[$];
  logic [7:0]      exp_q[$];
  logic [N_CH-1:0] ack_q[$];
  int              ack_cyc_q[$];
  int              dv_cyc_q[$];

  assign tx_active = model_active | force_active;
  assign tx_done   = model_done | inj_done;

  always #5 clk = ~clk;

  tdoa_uart_scheduler #(.N_CH(N_CH), .TS_W(TS_W), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ts_flat(ts_flat), .ack(ack),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_active(tx_active), .tx_done(tx_done),
    .busy(busy)
  );

  // uart_tx stand-in: BYTE_CYC cycles per byte, done pulse as active falls.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    model_done <= 1'b0;
    if (!model_active) begin
      if (tx_dv) begin
        model_active <= 1'b1;
        model_cnt    <= BYTE_CYC;
      end
    end else if (model_cnt == 1) begin
      model_active <= 1'b0;
      model_done   <= 1'b1;
    end else begin
      model_cnt <= model_cnt - 1;
    end
  end

  // Line-side monitor: records each handed-off byte and each ack.
  always @(negedge clk) begin
    if (tx_dv) begin
      rx_q.push_back(tx_byte);
      dv_cyc_q.push_back(cyc);
      $display("[%0d] byte 0x%02h", cyc, tx_byte);
      if (tx_active) dv_viol <= dv_viol + 1;
    end
    if (ack != '0) begin
      ack_q.push_back(ack);
      ack_cyc_q.push_back(cyc);
      $display("[%0d] ack %b", cyc, ack);
    end
  end

  task automatic clear_logs();
    rx_q.delete(); exp_q.delete(); ack_q.delete(); ack_cyc_q.delete(); dv_cyc_q.delete();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; req = '0; force_active = 1'b0; inj_done = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_logs();
  endtask

  // Expected packet for one channel/timestamp pair.
  task automatic exp_pkt(input logic [7:0] ch, input logic [31:0] ts);
    exp_q.push_back(8'hA5);
    exp_q.push_back(ch);
    for (int i = 3; i >= 0; i--) exp_q.push_back(ts[i*8 +: 8]);
`ifdef CHECKSUM_EN
    exp_q.push_back(8'hA5 ^ ch ^ ts[31:24] ^ ts[23:16] ^ ts[15:8] ^ ts[7:0]);
`endif
  endtask

  // Requester behaviour: drop req on ack; run until enough bytes and idle.
  task automatic run_drop(input int max_cyc, input int want_bytes, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      req = req & ~ack;
      if (rx_q.size() >= want_bytes && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 4'b1111;
    repeat (3) @(negedge clk);
    n_cmp++; if (ack !== 4'b0000) begin n_mis++; $display("FAIL reset_ack_held: got %b want 0000", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy_held: got %b want 0", busy); end
    req = '0; reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_dv !== 1'b0) begin n_mis++; $display("FAIL reset_tx_dv: got %b want 0", tx_dv); end
    n_cmp++; if (tx_byte !== 8'h00) begin n_mis++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (ack !== 4'b0000) begin n_mis++; $display("FAIL reset_ack: got %b want 0000", ack); end
  endtask

  task automatic test_single();
    bit ok;
    int req_cyc;
    logic [7:0] exp1 [7] = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h23, 8'h45, 8'hC0};
    apply_reset();
    ts_flat[2*TS_W +: TS_W] = 32'h0001_2345;
    req[2] = 1'b1;
    req_cyc = cyc;
    run_drop(400, PKT_LEN, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL single_timeout: got %0d bytes want %0d", rx_q.size(), PKT_LEN); end
    n_cmp++; if (ack_q.size() !== 1) begin n_mis++; $display("FAIL single_ack_count: got %0d want 1", ack_q.size()); end
    if (ack_q.size() >= 1) begin
      n_cmp++; if (ack_q[0] !== 4'b0100) begin n_mis++; $display("FAIL single_ack_onehot: got %b want 0100", ack_q[0]); end
      n_cmp++; if (ack_cyc_q[0] - req_cyc !== 2) begin n_mis++; $display("FAIL single_ack_latency: got %0d want 2", ack_cyc_q[0] - req_cyc); end
      if (dv_cyc_q.size() >= 1) begin
        n_cmp++; if (dv_cyc_q[0] - ack_cyc_q[0] !== 2) begin n_mis++; $display("FAIL single_dv_latency: got %0d want 2", dv_cyc_q[0] - ack_cyc_q[0]); end
      end
    end
    n_cmp++; if (rx_q.size() !== PKT_LEN) begin n_mis++; $display("FAIL single_len: got %0d want %0d", rx_q.size(), PKT_LEN); end
    for (int i = 0; i < PKT_LEN && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp1[i]) begin n_mis++; $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], exp1[i]); end
    end
  endtask

  task automatic test_all_req();
    bit ok;
    apply_reset();
    for (int k = 0; k < N_CH; k++) ts_flat[k*TS_W +: TS_W] = 32'(k + 1);
    for (int k = 0; k < N_CH; k++) exp_pkt(8'(k), 32'(k + 1));
    req = 4'b1111;
    run_drop(2000, 4*PKT_LEN, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL all_req_timeout: got %0d bytes want %0d", rx_q.size(), 4*PKT_LEN); end
    n_cmp++; if (ack_q.size() !== 4) begin n_mis++; $display("FAIL all_req_ack_count: got %0d want 4", ack_q.size()); end
    for (int k = 0; k < 4 && k < ack_q.size(); k++) begin
      n_cmp++; if (ack_q[k] !== 4'(1 << k)) begin n_mis++; $display("FAIL all_req_ack%0d: got %b want %b", k, ack_q[k], 4'(1 << k)); end
    end
    n_cmp++; if (rx_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL all_req_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL all_req_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_fairness();
    bit ok;
    bit rearm;
    logic [3:0] exp_acks [4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};
    apply_reset();
    ts_flat[0 +: TS_W]      = 32'h0000_0010;
    ts_flat[3*TS_W +: TS_W] = 32'h0000_0030;
    req = 4'b1001;
    rearm = 1'b0;
    for (int i = 0; i < 3000 && ack_q.size() < 4; i++) begin
      @(negedge clk);
      if (rearm) begin req[0] = 1'b1; rearm = 1'b0; end
      if (ack[0]) begin req[0] = 1'b0; rearm = 1'b1; end
    end
    req = '0;
    run_drop(400, 4*PKT_LEN, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL fair_timeout: got %0d bytes want %0d", rx_q.size(), 4*PKT_LEN); end
    n_cmp++; if (ack_q.size() !== 4) begin n_mis++; $display("FAIL fair_ack_count: got %0d want 4", ack_q.size()); end
    for (int k = 0; k < 4 && k < ack_q.size(); k++) begin
      n_cmp++; if (ack_q[k] !== exp_acks[k]) begin n_mis++; $display("FAIL fair_grant%0d: got %b want %b", k, ack_q[k], exp_acks[k]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int dv_cnt;
    apply_reset();
    ts_flat[0 +: TS_W] = 32'hCAFE_F00D;
    req[0] = 1'b1;
    dv_cnt = 0;
    for (int i = 0; i < 400 && dv_cnt < 3; i++) begin
      @(negedge clk);
      req = req & ~ack;
      if (tx_dv) dv_cnt++;
    end
    n_cmp++; if (dv_cnt !== 3) begin n_mis++; $display("FAIL mid_third_byte: got %0d strobes want 3", dv_cnt); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (tx_dv !== 1'b0) begin n_mis++; $display("FAIL mid_tx_dv: got %b want 0", tx_dv); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (ack !== 4'b0000) begin n_mis++; $display("FAIL mid_ack: got %b want 0000", ack); end
    apply_reset();
    repeat (30) @(negedge clk);
    n_cmp++; if (rx_q.size() !== 0) begin n_mis++; $display("FAIL mid_no_resume: got %0d bytes want 0", rx_q.size()); end
    ts_flat[1*TS_W +: TS_W] = 32'h1122_3344;
    exp_pkt(8'h01, 32'h1122_3344);
    req[1] = 1'b1;
    run_drop(400, PKT_LEN, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL mid_timeout: got %0d bytes want %0d", rx_q.size(), PKT_LEN); end
    n_cmp++; if (ack_q.size() !== 1 || ack_q[0] !== 4'b0010) begin n_mis++; $display("FAIL mid_ack_after: got %0d acks want one 0010", ack_q.size()); end
    n_cmp++; if (rx_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL mid_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL mid_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_latch();
    bit ok;
    apply_reset();
    ts_flat[3*TS_W +: TS_W] = 32'h89AB_CDEF;
    exp_pkt(8'h03, 32'h89AB_CDEF);
    req[3] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ack[3]) begin
        req[3] = 1'b0;
        ts_flat[3*TS_W +: TS_W] = 32'hFFFF_FFFF;
      end
      if (rx_q.size() >= PKT_LEN && !busy) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL latch_timeout: got %0d bytes want %0d", rx_q.size(), PKT_LEN); end
    n_cmp++; if (rx_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL latch_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL latch_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_tx_active();
    bit ok;
    int dv_forced;
    int release_cyc;
    int n_rx;
    int busy_seen;
    apply_reset();
    force_active = 1'b1;
    ts_flat[1*TS_W +: TS_W] = 32'h0000_0007;
    exp_pkt(8'h01, 32'h0000_0007);
    req[1] = 1'b1;
    dv_forced = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      req = req & ~ack;
      if (tx_dv) dv_forced++;
    end
    n_cmp++; if (dv_forced !== 0) begin n_mis++; $display("FAIL active_dv_held: got %0d strobes want 0", dv_forced); end
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL active_busy: got %b want 1", busy); end
    force_active = 1'b0;
    release_cyc = cyc;
    run_drop(400, PKT_LEN, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL active_timeout: got %0d bytes want %0d", rx_q.size(), PKT_LEN); end
    if (dv_cyc_q.size() >= 1) begin
      n_cmp++; if (dv_cyc_q[0] < release_cyc) begin n_mis++; $display("FAIL active_first_dv: got cycle %0d want >= %0d", dv_cyc_q[0], release_cyc); end
    end
    n_cmp++; if (rx_q.size() !== exp_q.size()) begin n_mis++; $display("FAIL active_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_mis++; $display("FAIL active_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    n_rx = rx_q.size();
    busy_seen = 0;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    n_cmp++; if (busy_seen !== 0) begin n_mis++; $display("FAIL idle_done_busy: got %0d busy cycles want 0", busy_seen); end
    n_cmp++; if (rx_q.size() !== n_rx) begin n_mis++; $display("FAIL idle_done_bytes: got %0d want %0d", rx_q.size(), n_rx); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_fairness();
    test_reset_mid();
    test_latch();
    test_tx_active();
    n_cmp++; if (dv_viol !== 0) begin n_mis++; $display("FAIL dv_while_active: got %0d want 0", dv_viol); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
